// File: rtl/dfi_gpio_bank_if.sv
// Register port bundle between the cpuif adapter and dfi_gpio_bank.
// One request per cycle, no stall; the response comes back on the next cycle.
interface dfi_gpio_bank_if;

   logic        req;
   logic        req_is_wr;
   logic [4:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] wr_biten;
   logic        rd_ack;
   logic        rd_err;
   logic [31:0] rd_data;
   logic        wr_ack;
   logic        wr_err;

   modport master (
      output req,
      output req_is_wr,
      output addr,
      output wr_data,
      output wr_biten,
      input  rd_ack,
      input  rd_err,
      input  rd_data,
      input  wr_ack,
      input  wr_err
   );

   modport slave (
      input  req,
      input  req_is_wr,
      input  addr,
      input  wr_data,
      input  wr_biten,
      output rd_ack,
      output rd_err,
      output rd_data,
      output wr_ack,
      output wr_err
   );

endinterface

// File: rtl/dfi_gpio_bank.sv
// DFI sideband GPIO bank: synchronised inputs with sticky edge capture and a
// maskable level interrupt, plus registered outputs with level and pulse modes.
module dfi_gpio_bank #(
   parameter int unsigned       NumIn       = 4,
   parameter int unsigned       NumOut      = 4,
   parameter int unsigned       SyncStages  = 2,
   parameter int unsigned       PulseCycles = 16,
   parameter logic [NumOut-1:0] OutResetVal = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   dfi_gpio_bank_if.slave    s_cpuif,
   input  logic [NumIn-1:0]  gpio_i,
   output logic [NumOut-1:0] gpio_o,
   output logic              irq_o
);

   localparam int unsigned CntW     = $clog2(PulseCycles + 1);
   localparam int unsigned PrimeLen = SyncStages + 1;
   localparam int unsigned PrimeW   = $clog2(PrimeLen + 1);

   // Word offsets (byte address bits [4:2])
   localparam logic [2:0] AddrInVal    = 3'd0;
   localparam logic [2:0] AddrInRise   = 3'd1;
   localparam logic [2:0] AddrInFall   = 3'd2;
   localparam logic [2:0] AddrIrqEn    = 3'd3;
   localparam logic [2:0] AddrOutVal   = 3'd4;
   localparam logic [2:0] AddrOutPulse = 3'd5;
   localparam logic [2:0] AddrOutSet   = 3'd6;
   localparam logic [2:0] AddrOutClr   = 3'd7;

   // ---------------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------------
   logic        wr_en;
   logic        rd_en;
   logic [2:0]  word;
   logic [31:0] wr_ones;   // bits written as 1 under the bit enable

   assign wr_en   = s_cpuif.req & s_cpuif.req_is_wr;
   assign rd_en   = s_cpuif.req & ~s_cpuif.req_is_wr;
   assign word    = s_cpuif.addr[4:2];
   assign wr_ones = s_cpuif.wr_data & s_cpuif.wr_biten;

   // Byte-lane bits and data above NumIn/NumOut carry no state
   logic unused_bus;
   assign unused_bus = ^{s_cpuif.addr[1:0], s_cpuif.wr_data, s_cpuif.wr_biten};

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [NumIn-1:0]  sync_q [SyncStages];
   logic [NumIn-1:0]  in_val;
   logic [NumIn-1:0]  in_prev_q;
   logic [PrimeW-1:0] prime_q;
   logic              capture;

   logic [NumIn-1:0]  rise_q, rise_d;
   logic [NumIn-1:0]  fall_q, fall_d;
   logic [NumIn-1:0]  rise_clr, fall_clr;
   logic [NumIn-1:0]  irq_en_q, irq_en_d;
   logic              irq_q, irq_d;

   logic [NumOut-1:0] out_val_q, out_val_d;
   logic [NumOut-1:0] pulse_start;
   logic [NumOut-1:0] pulse_act;
   logic [CntW-1:0]   cnt_q [NumOut];
   logic [CntW-1:0]   cnt_d [NumOut];
   logic [NumOut-1:0] gpio_q, gpio_d;

   logic              rd_ack_q, wr_ack_q;
   logic              rd_err_q, wr_err_q;
   logic              wr_err_d;
   logic [31:0]       rd_data_q, rd_data_d;

   assign in_val  = sync_q[SyncStages-1];
   assign capture = (prime_q == PrimeW'(PrimeLen));

   // Register writes and read mux; writes to IN_VAL error and touch nothing
   always_comb begin
      rise_clr    = '0;
      fall_clr    = '0;
      irq_en_d    = irq_en_q;
      out_val_d   = out_val_q;
      pulse_start = '0;
      wr_err_d    = 1'b0;
      rd_data_d   = '0;
      if (wr_en) begin
         unique case (word)
            AddrInVal:    wr_err_d = 1'b1;
            AddrInRise:   rise_clr = wr_ones[NumIn-1:0];
            AddrInFall:   fall_clr = wr_ones[NumIn-1:0];
            AddrIrqEn:    irq_en_d = (irq_en_q & ~s_cpuif.wr_biten[NumIn-1:0])
                                     | wr_ones[NumIn-1:0];
            AddrOutVal:   out_val_d = (out_val_q & ~s_cpuif.wr_biten[NumOut-1:0])
                                      | wr_ones[NumOut-1:0];
            AddrOutPulse: pulse_start = wr_ones[NumOut-1:0];
            AddrOutSet:   out_val_d = out_val_q | wr_ones[NumOut-1:0];
            AddrOutClr:   out_val_d = out_val_q & ~wr_ones[NumOut-1:0];
         endcase
      end
      if (rd_en) begin
         unique case (word)
            AddrInVal:    rd_data_d[NumIn-1:0]  = in_val;
            AddrInRise:   rd_data_d[NumIn-1:0]  = rise_q;
            AddrInFall:   rd_data_d[NumIn-1:0]  = fall_q;
            AddrIrqEn:    rd_data_d[NumIn-1:0]  = irq_en_q;
            AddrOutVal:   rd_data_d[NumOut-1:0] = gpio_q;
            AddrOutPulse: rd_data_d             = '0;
            AddrOutSet:   rd_data_d             = '0;
            AddrOutClr:   rd_data_d             = '0;
         endcase
      end
   end

   // Sticky edge capture; a hardware set beats a same-cycle W1C
   always_comb begin
      rise_d = rise_q & ~rise_clr;
      fall_d = fall_q & ~fall_clr;
      if (capture) begin
         rise_d = rise_d | (in_val & ~in_prev_q);
         fall_d = fall_d | (~in_val & in_prev_q);
      end
      irq_d = |(irq_en_q & (rise_q | fall_q));
   end

   // Pulse counters: load on write (reload extends), otherwise count down to 0
   always_comb begin
      for (int i = 0; i < int'(NumOut); i++) begin
         pulse_act[i] = (cnt_q[i] != '0);
         if (pulse_start[i]) begin
            cnt_d[i] = CntW'(PulseCycles);
         end else if (pulse_act[i]) begin
            cnt_d[i] = cnt_q[i] - CntW'(1);
         end else begin
            cnt_d[i] = cnt_q[i];
         end
      end
      gpio_d = out_val_q | pulse_act;
   end

   // Input synchroniser, edge reference and post-reset prime window
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < int'(SyncStages); s++) sync_q[s] <= '0;
         in_prev_q <= '0;
         prime_q   <= '0;
      end else begin
         sync_q[0] <= gpio_i;
         for (int s = 1; s < int'(SyncStages); s++) sync_q[s] <= sync_q[s-1];
         in_prev_q <= in_val;
         if (!capture) prime_q <= prime_q + PrimeW'(1);
      end
   end

   // Input-side registers: sticky status, enables and interrupt
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rise_q   <= '0;
         fall_q   <= '0;
         irq_en_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

   // Output-side registers: level register, pulse counters and driven pins
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_val_q <= OutResetVal;
         gpio_q    <= OutResetVal;
         for (int i = 0; i < int'(NumOut); i++) cnt_q[i] <= '0;
      end else begin
         out_val_q <= out_val_d;
         gpio_q    <= gpio_d;
         for (int i = 0; i < int'(NumOut); i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // Single-cycle response one clock after each request
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ack_q  <= 1'b0;
         wr_ack_q  <= 1'b0;
         rd_err_q  <= 1'b0;
         wr_err_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         rd_ack_q  <= rd_en;
         wr_ack_q  <= wr_en;
         // All eight word slots of the 5-bit space decode, so reads never error
         rd_err_q  <= 1'b0;
         wr_err_q  <= wr_err_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign s_cpuif.rd_ack  = rd_ack_q;
   assign s_cpuif.rd_err  = rd_err_q;
   assign s_cpuif.rd_data = rd_data_q;
   assign s_cpuif.wr_ack  = wr_ack_q;
   assign s_cpuif.wr_err  = wr_err_q;
   assign gpio_o          = gpio_q;
   assign irq_o           = irq_q;

endmodule
